// File: rtl/smg_scan_ctrl_if.sv
// smg_scan_ctrl_if
// Bundles the application-side load strobe and display data with the
// pin-side segment/scan outputs of the seven-segment scanner.
//   master : application / testbench (drives Load and data, watches pins)
//   slave  : smg_scan_ctrl
// Signals:
//   Load        single-cycle strobe that samples the data fields
//   Hex_In      packed nibbles, nibble k = digit k (digit 0 rightmost)
//   DP_In       per-digit decimal point
//   Blank_In    per-digit forced dark
//   LZ_En       leading-zero suppression enable
//   Brightness  PWM duty level, all-ones = maximum
//   SMG_Data    segment pins {dp,g,f,e,d,c,b,a}
//   Scan_Sig    one-hot digit select pins
//   Frame_Done  one-cycle pulse at the end of each frame
interface smg_scan_ctrl_if #(
  parameter int DIGITS    = 6,
  parameter int DUTY_BITS = 4
);
  logic                  Load;
  logic [4*DIGITS-1:0]   Hex_In;
  logic [DIGITS-1:0]     DP_In;
  logic [DIGITS-1:0]     Blank_In;
  logic                  LZ_En;
  logic [DUTY_BITS-1:0]  Brightness;
  logic [7:0]            SMG_Data;
  logic [DIGITS-1:0]     Scan_Sig;
  logic                  Frame_Done;

  modport master (
    output Load, Hex_In, DP_In, Blank_In, LZ_En, Brightness,
    input  SMG_Data, Scan_Sig, Frame_Done
  );

  modport slave (
    input  Load, Hex_In, DP_In, Blank_In, LZ_En, Brightness,
    output SMG_Data, Scan_Sig, Frame_Done
  );
endinterface

// File: rtl/smg_scan_ctrl.sv
// smg_scan_ctrl
// Multiplexed seven-segment scanner with per-digit decimal point and
// blanking, leading-zero suppression, PWM brightness and frame-synchronous
// (tear-free) display updates.
// Ports:
//   CLK  system clock
//   RST  synchronous active-high reset
//   bus  smg_scan_ctrl_if.slave : Load/Hex_In/DP_In/Blank_In/LZ_En/
//        Brightness in, SMG_Data/Scan_Sig/Frame_Done out (all registered)
module smg_scan_ctrl #(
  parameter int DIGITS          = 6,
  parameter int SCAN_DIV        = 50000,
  parameter int DUTY_BITS       = 4,
  parameter bit SEG_ACTIVE_LOW  = 1'b1,
  parameter bit SCAN_ACTIVE_LOW = 1'b1
) (
  input logic           CLK,
  input logic           RST,
  smg_scan_ctrl_if.slave bus
);

  localparam int SW = $clog2(SCAN_DIV);
  localparam int DW = $clog2(DIGITS);

  logic [SW-1:0]              slot_cnt;
  logic [DW-1:0]              digit_idx;

  // Shadow set collects Loads; active set is what is being scanned out.
  logic [DIGITS-1:0][3:0]     shd_hex, act_hex;
  logic [DIGITS-1:0]          shd_dp, act_dp;
  logic [DIGITS-1:0]          shd_blank, act_blank;
  logic                       shd_lz, act_lz;
  logic [DUTY_BITS-1:0]       shd_bright, act_bright;
  logic                       pending;

  logic                       slot_last;
  logic                       boundary;
  logic [DIGITS-1:0]          supp;
  logic                       leading;
  logic                       dark;
  logic                       window;
  logic [7:0]                 seg_raw;
  logic [DIGITS-1:0]          scan_raw;

  function automatic logic [6:0] decode(input logic [3:0] nib);
    case (nib)
      4'h0: decode = 7'h3F;
      4'h1: decode = 7'h06;
      4'h2: decode = 7'h5B;
      4'h3: decode = 7'h4F;
      4'h4: decode = 7'h66;
      4'h5: decode = 7'h6D;
      4'h6: decode = 7'h7D;
      4'h7: decode = 7'h07;
      4'h8: decode = 7'h7F;
      4'h9: decode = 7'h6F;
      4'hA: decode = 7'h77;
      4'hB: decode = 7'h7C;
      4'hC: decode = 7'h39;
      4'hD: decode = 7'h5E;
      4'hE: decode = 7'h79;
      default: decode = 7'h71;
    endcase
  endfunction

  assign slot_last = (slot_cnt == SW'(SCAN_DIV - 1));
  assign boundary  = slot_last && (digit_idx == DW'(DIGITS - 1));

  // Walk down from the most significant digit; a zero nibble without a
  // decimal point stays dark until the first significant digit is met.
  // Digit 0 is never considered so a zero value still shows "0".
  always_comb begin
    supp    = '0;
    leading = act_lz;
    for (int k = DIGITS - 1; k >= 1; k--) begin
      if (leading && (act_hex[k] == 4'h0) && !act_dp[k])
        supp[k] = 1'b1;
      else
        leading = 1'b0;
    end
  end

  // Slot cycle 0 is always off so the previous digit's select has fully
  // released before the next digit drives (prevents ghosting).
  always_comb begin
    dark     = act_blank[digit_idx] | supp[digit_idx];
    window   = (slot_cnt != '0) && (slot_cnt[DUTY_BITS-1:0] <= act_bright);
    seg_raw  = dark ? 8'h00 : {act_dp[digit_idx], decode(act_hex[digit_idx])};
    scan_raw = '0;
    if (!dark && window)
      scan_raw[digit_idx] = 1'b1;
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      slot_cnt       <= '0;
      digit_idx      <= '0;
      pending        <= 1'b0;
      shd_hex        <= '0;
      shd_dp         <= '0;
      shd_blank      <= '0;
      shd_lz         <= 1'b0;
      shd_bright     <= '0;
      act_hex        <= '0;
      act_dp         <= '0;
      act_blank      <= '1;
      act_lz         <= 1'b0;
      act_bright     <= '1;
      bus.SMG_Data   <= {8{SEG_ACTIVE_LOW}};
      bus.Scan_Sig   <= {DIGITS{SCAN_ACTIVE_LOW}};
      bus.Frame_Done <= 1'b0;
    end else begin
      if (slot_last) begin
        slot_cnt  <= '0;
        digit_idx <= (digit_idx == DW'(DIGITS - 1)) ? '0 : digit_idx + DW'(1);
      end else begin
        slot_cnt  <= slot_cnt + SW'(1);
      end

      if (bus.Load) begin
        shd_hex    <= bus.Hex_In;
        shd_dp     <= bus.DP_In;
        shd_blank  <= bus.Blank_In;
        shd_lz     <= bus.LZ_En;
        shd_bright <= bus.Brightness;
      end

      // A Load landing exactly on the boundary bypasses the shadow so it
      // is not delayed by a whole frame.
      if (boundary) begin
        pending <= 1'b0;
        if (bus.Load) begin
          act_hex    <= bus.Hex_In;
          act_dp     <= bus.DP_In;
          act_blank  <= bus.Blank_In;
          act_lz     <= bus.LZ_En;
          act_bright <= bus.Brightness;
        end else if (pending) begin
          act_hex    <= shd_hex;
          act_dp     <= shd_dp;
          act_blank  <= shd_blank;
          act_lz     <= shd_lz;
          act_bright <= shd_bright;
        end
      end else if (bus.Load) begin
        pending <= 1'b1;
      end

      bus.SMG_Data   <= seg_raw ^ {8{SEG_ACTIVE_LOW}};
      bus.Scan_Sig   <= scan_raw ^ {DIGITS{SCAN_ACTIVE_LOW}};
      bus.Frame_Done <= boundary;
    end
  end

endmodule

// File: doc/smg_scan_ctrl.md
# smg_scan_ctrl

Parametrised multiplexed seven-segment display controller. Drives DIGITS common-anode/common-cathode digits from a packed hex word, with per-digit decimal point and blanking, leading-zero suppression, PWM brightness and tear-free frame-synchronous updates. Sits between the application datapath and the board's SMG_Data/Scan_Sig pins, replacing the fixed 6-digit scanner in Module_Top.

## Interface
- DIGITS, 6, number of digits scanned (2..8)
- SCAN_DIV, 50000, clock cycles per digit slot; multiple of 2^DUTY_BITS
- DUTY_BITS, 4, brightness resolution in bits
- SEG_ACTIVE_LOW, 1, 1 = segment outputs inverted at the pin
- SCAN_ACTIVE_LOW, 1, 1 = digit-select outputs inverted at the pin

- CLK  in  1  system clock; the only clock
- RST  in  1  reset; synchronous, active-high
- Load  in  1  single-cycle strobe; samples Hex_In, DP_In, Blank_In, LZ_En, Brightness
- Hex_In  in  4*DIGITS  nibble k = value of digit k (digit 0 = rightmost)
- DP_In  in  DIGITS  bit k lights decimal point of digit k
- Blank_In  in  DIGITS  bit k forces digit k dark
- LZ_En  in  1  enable leading-zero suppression
- Brightness  in  DUTY_BITS  duty level; all-ones = maximum
- SMG_Data  out  8  segments {dp,g,f,e,d,c,b,a}, registered
- Scan_Sig  out  DIGITS  one-hot digit select, registered
- Frame_Done  out  1  one-cycle pulse at end of last digit slot

## Operation
- Two register sets: shadow (written by Load) and active (drives display). Load writes shadow and sets pending; last Load before a boundary wins.
- Frame boundary = cycle with slot_cnt = SCAN_DIV-1 and digit_idx = DIGITS-1. At that edge, if Load is high, active <= inputs directly; else if pending, active <= shadow; pending clears.
- slot_cnt counts 0..SCAN_DIV-1, wraps; digit_idx increments on wrap, 0..DIGITS-1, wraps to 0.
- Decoder (active-high, pre-inversion): 0=3F 1=06 2=5B 3=4F 4=66 5=6D 6=7D 7=07 8=7F 9=6F A=77 b=7C C=39 d=5E E=79 F=71; bit 7 = DP.
- Leading-zero suppression (LZ_En=1): scanning from digit DIGITS-1 downward, digits with nibble 0 and DP clear are dark until the first nonzero nibble or set DP; digit 0 never suppressed.
- Digit k dark if Blank[k] or suppressed: SMG_Data shows all-off, Scan_Sig all-off for its slot.
- Enable window: Scan_Sig asserted for current digit when slot_cnt != 0 (anti-ghost guard) and slot_cnt[DUTY_BITS-1:0] <= Brightness. Outside window Scan_Sig all-off; SMG_Data still carries the digit pattern.
- Polarity inversion applied only at output registers.

## Timing
- Outputs registered: values in cycle n+1 derive from counter/active state in cycle n; latency 1 clock.
- Frame length = DIGITS*SCAN_DIV cycles; Frame_Done registered, high for exactly 1 cycle per frame.
- New data visible from first slot of the frame following the boundary edge; never mid-frame.
- Reset (any time, including mid-frame), effective next edge: slot_cnt=0, digit_idx=0, pending=0, shadow=0, active Hex/DP=0, active Blank=all-ones, Brightness=all-ones, LZ_En=0; SMG_Data=all-off (8'hFF active-low), Scan_Sig=all-off, Frame_Done=0. Display dark until first post-reset Load is applied at a boundary.
- Load during RST ignored.

## Test plan
Config DIGITS=4, SCAN_DIV=8, DUTY_BITS=2, both polarities active-low.
- Reset 3 cycles -> SMG_Data=8'hFF, Scan_Sig=4'hF, Frame_Done=0; first frame after release fully dark; Frame_Done pulses every 32 cycles.
- Load Hex_In=16'h1234, DP=0, Blank=0, Brightness=3 -> after next boundary digit 0: SMG_Data=8'h99, Scan_Sig=4'b1110 for 7 of 8 slot cycles; then digits 1..3 show 8'hB0, 8'hA4, 8'hF9.
- Brightness=1 -> Scan_Sig active at slot_cnt 1,4,5 only (3 of 8 cycles per slot).
- LZ_En=1, Hex_In=16'h0050 -> digits 3,2 dark, digit 1 = 8'h92, digit 0 = 8'hC0; add DP_In[2]=1 -> digit 2 = 8'h40, digit 3 dark.
- Load mid-frame (slot 1 of frame) then second Load with 16'hABCD -> no change until boundary, then ABCD displayed; Load on boundary cycle applies in immediately following frame.
- RST asserted mid-slot of digit 2 -> next cycle outputs all-off, counters 0, display dark until new Load.
